// File: rtl/lab_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lab_access_pkg
// Description : Shared encodings for the lab access badge terminal: request
//               modes, lab identifiers, denial reasons and terminal states.
// Revision    : 1.0 - initial release
// ============================================================================
package lab_access_pkg;

    // Request mode presented to the access controller
    localparam logic [1:0] MODE_EXIT  = 2'b00;
    localparam logic [1:0] MODE_ENTER = 2'b01;
    localparam logic [1:0] MODE_IDLE  = 2'b10;

    // Lab selection
    localparam logic LAB_DIGITAL = 1'b0;
    localparam logic LAB_MERA    = 1'b1;

    // Reason shown alongside the denial indicator
    localparam logic [1:0] DENY_NONE     = 2'b00;
    localparam logic [1:0] DENY_RESTRICT = 2'b01;
    localparam logic [1:0] DENY_NORESP   = 2'b10;

    // Badge frame geometry
    localparam int CODE_W   = 5;
    localparam int BITCNT_W = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        DOOR  = 3'd4,
        DENY  = 3'd5
    } state_t;

    // Direction button to controller request mode
    function automatic logic [1:0] reqMode(input logic dir);
        return dir ? MODE_ENTER : MODE_EXIT;
    endfunction

endpackage
`default_nettype wire

// File: rtl/badge_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : badge_deserializer
// Description : Collects a 5-bit LSB-first badge frame from strobed serial
//               bits. Publishes the code only when a frame completes; a frame
//               that stalls for BIT_GAP idle cycles is dropped silently.
// Revision    : 1.0 - initial release
// ============================================================================
module badge_deserializer
    import lab_access_pkg::*;
#(
    parameter int BIT_GAP = 16,
    parameter int GAP_W   = $clog2(BIT_GAP) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              accept,
    input  logic              cardStrobe,
    input  logic              cardBit,
    output logic [CODE_W-1:0] code,
    output logic              frameStart,
    output logic              frameDone,
    output logic              frameAbort
);

    localparam logic [GAP_W-1:0]    c_GAP_LAST = GAP_W'(BIT_GAP - 1);
    localparam logic [BITCNT_W-1:0] c_LAST_BIT = BITCNT_W'(CODE_W - 1);

    logic [CODE_W-1:0]   r_shift;
    logic [CODE_W-1:0]   r_code;
    logic [BITCNT_W-1:0] r_bitCnt;
    logic [GAP_W-1:0]    r_gapCnt;
    logic                w_take;
    logic [CODE_W-1:0]   w_shiftNext;

    // Frame event decode and next shift-register image with the incoming bit placed
    always_comb begin
        w_take      = accept && cardStrobe;
        frameStart  = w_take && (r_bitCnt == '0);
        frameDone   = w_take && (r_bitCnt == c_LAST_BIT);
        frameAbort  = accept && !cardStrobe && (r_bitCnt != '0) && (r_gapCnt == c_GAP_LAST);
        w_shiftNext = (r_bitCnt == '0) ? '0 : r_shift;
        w_shiftNext[r_bitCnt] = cardBit;
    end

    // Shift register, bit position, inter-bit gap timer and published code
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_shift  <= '0;
            r_code   <= '0;
            r_bitCnt <= '0;
            r_gapCnt <= '0;
        end else if (w_take) begin
            r_gapCnt <= '0;
            if (frameDone) begin
                r_code   <= w_shiftNext;
                r_shift  <= '0;
                r_bitCnt <= '0;
            end else begin
                r_shift  <= w_shiftNext;
                r_bitCnt <= r_bitCnt + BITCNT_W'(1);
            end
        end else if (frameAbort) begin
            // Published code is deliberately left untouched on a dropped frame
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_gapCnt <= '0;
        end else if (r_bitCnt != '0) begin
            r_gapCnt <= r_gapCnt + GAP_W'(1);
        end
    end

    assign code = r_code;

endmodule
`default_nettype wire

// File: rtl/lab_badge_terminal.sv
`default_nettype none
// ============================================================================
// Module      : lab_badge_terminal
// Description : Door-side initiator for the lab access controller. Turns a
//               badge frame plus lab/direction buttons into a single request
//               cycle, waits for unlock/restrictionWarn, then times the door
//               strike or denial indicator and counts granted passages.
// Revision    : 1.0 - initial release
// ============================================================================
module lab_badge_terminal
    import lab_access_pkg::*;
#(
    parameter int DOOR_CYCLES  = 8,
    parameter int WARN_CYCLES  = 4,
    parameter int BIT_GAP      = 16,
    parameter int RESP_TIMEOUT = 3
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              cardStrobe,
    input  logic              cardBit,
    input  logic              labSel,
    input  logic              dirSel,
    input  logic              unlockIn,
    input  logic              warnIn,
    output logic [CODE_W-1:0] smartCode,
    output logic              lab,
    output logic [1:0]        mode,
    output logic              doorOpen,
    output logic              denyLed,
    output logic [1:0]        denyReason,
    output logic              busy,
    output logic [7:0]        grantCount
);

    // All timers share one width sized by the largest interval parameter
    localparam int c_MAX_AB  = (DOOR_CYCLES > WARN_CYCLES) ? DOOR_CYCLES : WARN_CYCLES;
    localparam int c_MAX_CD  = (BIT_GAP > RESP_TIMEOUT) ? BIT_GAP : RESP_TIMEOUT;
    localparam int c_MAX     = (c_MAX_AB > c_MAX_CD) ? c_MAX_AB : c_MAX_CD;
    localparam int c_TIMER_W = $clog2(c_MAX) + 1;

    localparam logic [c_TIMER_W-1:0] c_DOOR_LAST = c_TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_WARN_LAST = c_TIMER_W'(WARN_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_RESP_LAST = c_TIMER_W'(RESP_TIMEOUT - 1);

    state_t               r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic                 r_labLatched;
    logic                 r_dirLatched;
    logic                 r_lab;
    logic [1:0]           r_mode;
    logic                 r_doorOpen;
    logic                 r_denyLed;
    logic [1:0]           r_denyReason;
    logic                 r_busy;
    logic [7:0]           r_grantCount;

    logic                 w_accept;
    logic                 w_frameStart;
    logic                 w_frameDone;
    logic                 w_frameAbort;
    logic [CODE_W-1:0]    w_code;

    // Badge bits are only taken while no transaction is in flight
    assign w_accept = (r_state == IDLE) || (r_state == SHIFT);

    badge_deserializer #(
        .BIT_GAP (BIT_GAP),
        .GAP_W   (c_TIMER_W)
    ) u_deser (
        .CLK        (CLK),
        .RST        (RST),
        .accept     (w_accept),
        .cardStrobe (cardStrobe),
        .cardBit    (cardBit),
        .code       (w_code),
        .frameStart (w_frameStart),
        .frameDone  (w_frameDone),
        .frameAbort (w_frameAbort)
    );

    // Terminal sequencer: request, response wait, door/denial timing, grant count
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_timer      <= '0;
            r_labLatched <= LAB_DIGITAL;
            r_dirLatched <= 1'b0;
            r_lab        <= LAB_DIGITAL;
            r_mode       <= MODE_IDLE;
            r_doorOpen   <= 1'b0;
            r_denyLed    <= 1'b0;
            r_denyReason <= DENY_NONE;
            r_busy       <= 1'b0;
            r_grantCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_frameStart) begin
                        r_state      <= SHIFT;
                        r_labLatched <= labSel;
                        r_dirLatched <= dirSel;
                        r_busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_frameDone) begin
                        r_state <= REQ;
                        r_mode  <= reqMode(r_dirLatched);
                        r_lab   <= r_labLatched;
                    end else if (w_frameAbort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                REQ: begin
                    r_state <= WAIT;
                    r_mode  <= MODE_IDLE;
                    r_timer <= '0;
                end
                WAIT: begin
                    if (unlockIn) begin
                        r_state    <= DOOR;
                        r_doorOpen <= 1'b1;
                        r_timer    <= '0;
                        if (r_grantCount != 8'hFF) begin
                            r_grantCount <= r_grantCount + 8'd1;
                        end
                    end else if (warnIn) begin
                        r_state      <= DENY;
                        r_denyLed    <= 1'b1;
                        r_denyReason <= DENY_RESTRICT;
                        r_timer      <= '0;
                    end else if (r_timer == c_RESP_LAST) begin
                        r_state      <= DENY;
                        r_denyLed    <= 1'b1;
                        r_denyReason <= DENY_NORESP;
                        r_timer      <= '0;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                DOOR: begin
                    if (r_timer == c_DOOR_LAST) begin
                        r_state    <= IDLE;
                        r_doorOpen <= 1'b0;
                        r_busy     <= 1'b0;
                        r_timer    <= '0;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                DENY: begin
                    if (r_timer == c_WARN_LAST) begin
                        r_state      <= IDLE;
                        r_denyLed    <= 1'b0;
                        r_denyReason <= DENY_NONE;
                        r_busy       <= 1'b0;
                        r_timer      <= '0;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_mode       <= MODE_IDLE;
                    r_doorOpen   <= 1'b0;
                    r_denyLed    <= 1'b0;
                    r_denyReason <= DENY_NONE;
                    r_busy       <= 1'b0;
                    r_timer      <= '0;
                end
            endcase
        end
    end

    assign smartCode  = w_code;
    assign lab        = r_lab;
    assign mode       = r_mode;
    assign doorOpen   = r_doorOpen;
    assign denyLed    = r_denyLed;
    assign denyReason = r_denyReason;
    assign busy       = r_busy;
    assign grantCount = r_grantCount;

endmodule
`default_nettype wire

// File: doc/lab_badge_terminal.md
Name: lab_badge_terminal

Overview:
- Door-side initiator for the lab access controller.
- Assembles a 5-bit smartCode from a serial badge reader and latches the lab and direction buttons.
- Issues exactly one enter (01) or exit (00) request cycle to the controller, then waits for its unlock or restrictionWarn response.
- Drives the physical door strike or denial indicator for a timed interval, and keeps a saturating grant count.

Parameters:
- DOOR_CYCLES, 8: cycles doorOpen stays high after a grant.
- WARN_CYCLES, 4: cycles denyLed stays high after a denial.
- BIT_GAP, 16: maximum idle cycles between badge bits before the frame is discarded.
- RESP_TIMEOUT, 3: cycles waited for a controller response.

Ports:
- CLK  in  1  system clock, all state on posedge.
- RST  in  1  synchronous reset, active-high.
- cardStrobe  in  1  one-cycle pulse: cardBit is valid this cycle.
- cardBit  in  1  serial badge bit, LSB first.
- labSel  in  1  0 = Digital, 1 = Mera; sampled on the first bit of a frame.
- dirSel  in  1  0 = exit, 1 = enter; sampled on the first bit of a frame.
- unlockIn  in  1  controller unlock for the selected lab.
- warnIn  in  1  controller restrictionWarn for the selected lab.
- smartCode  out  5  assembled badge code to the controller.
- lab  out  1  lab select to the controller.
- mode  out  2  00 exit, 01 enter, 10 idle.
- doorOpen  out  1  door strike drive.
- denyLed  out  1  denial indicator.
- denyReason  out  2  00 none, 01 restriction, 10 no response (full/empty).
- busy  out  1  high in every state except IDLE.
- grantCount  out  8  saturating count of granted passages.

Behaviour:
- Reset values: smartCode 0, lab 0, mode 2'b10, doorOpen 0, denyLed 0, denyReason 00, busy 0, grantCount 0, state IDLE, all counters 0.
- RST wins over every other input in the same cycle, including mid-frame and mid-door. The door closes on the next edge.
- mode is 2'b10 in every state except REQ.
- State IDLE:
  - cardStrobe: shift cardBit into bit 0, latch labSel/dirSel, bitCnt = 1, go to SHIFT.
  - Non-strobe cycles: all inputs ignored.
- State SHIFT:
  - Each cardStrobe stores cardBit at position bitCnt and increments bitCnt. The first bit lands at smartCode[0].
  - When the 5th bit arrives, go to REQ on the next edge.
  - gapCnt counts cycles with no strobe. When it reaches BIT_GAP, discard the frame, return to IDLE, and leave smartCode at its previous value.
  - labSel/dirSel changes during SHIFT are ignored.
- State REQ:
  - Lasts exactly 1 cycle. mode = {1'b0, dirLatched}, lab = labLatched, smartCode stable.
  - Then go to WAIT with waitCnt = 0.
- State WAIT:
  - The controller answers on the edge that samples REQ, so unlockIn/warnIn are valid from the first WAIT cycle.
  - unlockIn = 1: go to DOOR. grantCount increments, saturating at 255.
  - Else if warnIn = 1: go to DENY with reason 01.
  - Else if waitCnt == RESP_TIMEOUT-1: go to DENY with reason 10. This covers entry at 30 and exit when empty.
  - If unlockIn and warnIn are high together, unlock wins.
- State DOOR:
  - doorOpen = 1 for exactly DOOR_CYCLES cycles, then return to IDLE.
  - cardStrobe is ignored; a new badge must wait.
- State DENY:
  - denyLed = 1 and denyReason held for WARN_CYCLES cycles.
  - On exit to IDLE, denyReason returns to 00.
- smartCode/lab keep their last values after a transaction until the next complete frame.
- Arithmetic: timers are $clog2(max param)+1 bits, unsigned. grantCount never wraps.

Decomposition:
- Shared package lab_access_pkg:
  - Mode encodings MODE_EXIT = 2'b00, MODE_ENTER = 2'b01, MODE_IDLE = 2'b10.
  - LAB_DIGITAL = 0, LAB_MERA = 1.
  - Deny-reason constants.
  - State enum IDLE/SHIFT/REQ/WAIT/DOOR/DENY.
- One natural sub-module: badge_deserializer. It covers the 5-bit shift register, bitCnt, gap timeout, and a frameDone pulse. The FSM and timers stay in the top module.

Test Plan:
- Reset, then bits 1,0,1,1,0 with labSel = 1, dirSel = 1 -> smartCode = 5'b01101, one cycle of mode = 01 with lab = 1. With unlockIn pulsed in WAIT -> doorOpen high for 8 cycles, grantCount = 1.
- Enter request, warnIn = 1 in the first WAIT cycle -> denyLed high for 4 cycles, denyReason = 01, grantCount unchanged, doorOpen never high.
- Exit request with no response -> DENY after 3 WAIT cycles, denyReason = 10.
- 3 bits then 16 idle cycles -> return to IDLE, no REQ cycle. A subsequent full 5-bit frame completes normally.
- RST asserted during the 3rd DOOR cycle -> next edge: doorOpen = 0, mode = 10, grantCount = 0.
- 260 granted passages -> grantCount = 255. Strobes during DOOR never alter smartCode.
